rotate_scan_ctrl: RTL and testbench
===================================

ROTATE_SCAN_CTRL -- requirements
Module: rotate_scan_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_SIZE, default 64, the square image edge in pixels (power of two).
REQ-002 SHALL have parameter COOR_WIDTH, default 6, the coordinate width, equal to log2(IMAGE_SIZE).
REQ-003 SHALL have parameter ANG_WIDTH, default 9, the signed angle width in degrees.
REQ-004 SHALL have parameter PIX_WIDTH, default 16, the pixel data width.
REQ-005 SHALL have parameter BG_PIXEL, default 0, the pixel value emitted for out-of-range source points.
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port i_start, input, 1: frame request; i_angle is sampled on the same edge.
REQ-009 SHALL have port i_angle, input, ANG_WIDTH signed: rotation angle, -180..180.
REQ-010 SHALL have ports o_rot_start (out, 1), o_rot_H (out, COOR_WIDTH), o_rot_V (out, COOR_WIDTH) and o_rot_angle (out, ANG_WIDTH): rotator command.
REQ-011 SHALL have ports i_rot_valid (in, 1), i_rot_H (in, COOR_WIDTH), i_rot_V (in, COOR_WIDTH) and i_rot_oor (in, 1): rotator result, where i_rot_oor flags an out-of-range source.
REQ-012 SHALL have ports o_rd_req (out, 1), o_rd_H (out, COOR_WIDTH), o_rd_V (out, COOR_WIDTH), i_rd_valid (in, 1) and i_rd_data (in, PIX_WIDTH): SRAM read port.
REQ-013 SHALL have ports o_pix_valid (out, 1), i_pix_ready (in, 1), o_pix (out, PIX_WIDTH), o_pix_H (out, COOR_WIDTH) and o_pix_V (out, COOR_WIDTH): output pixel stream.
REQ-014 SHALL have ports o_busy (out, 1), o_done (out, 1, one-cycle pulse) and o_err (out, 1, one-cycle pulse).

Function
REQ-015 SHALL implement a state machine with states IDLE, ROT, WAIT_ROT, READ, OUT and DONE.
REQ-016 In IDLE with i_start=1: SHALL latch i_angle, clear the destination counters (H=0, V=0) and move to ROT.
REQ-017 ROT SHALL last exactly one cycle, with o_rot_start=1, o_rot_H/V set to the counters and o_rot_angle set to the latched angle, then move to WAIT_ROT.
REQ-018 WAIT_ROT on i_rot_valid=1: if i_rot_oor=1, SHALL load o_pix=BG_PIXEL and go to OUT; otherwise SHALL register i_rot_H/V and go to READ.
REQ-019 READ: SHALL hold o_rd_req=1 with o_rd_H/V stable until i_rd_valid=1, then register i_rd_data into o_pix and go to OUT; a same-cycle i_rd_valid is legal.
REQ-020 OUT: SHALL hold o_pix_valid=1 with o_pix and o_pix_H/V (the destination counters) stable until i_pix_ready=1.
REQ-021 On the OUT handshake: SHALL increment H; when H wraps from IMAGE_SIZE-1 to 0, SHALL increment V; after pixel (IMAGE_SIZE-1, IMAGE_SIZE-1), SHALL go to DONE, otherwise to ROT.
REQ-022 DONE SHALL last one cycle with o_done=1, then return to IDLE.
REQ-023 o_busy SHALL be 1 in every state except IDLE.
REQ-024 i_start SHALL be ignored outside IDLE, and the angle is not re-sampled mid-frame.
REQ-025 i_rot_valid SHALL be ignored outside WAIT_ROT, and i_rd_valid outside READ.
REQ-026 All outputs SHALL be registered; minimum per-pixel cost is 4 cycles (ROT, WAIT_ROT, READ, OUT) when results arrive in the entry cycle and ready is high.

Reset
REQ-027 On i_rst=1 at a clock edge, SHALL enter IDLE from any state, aborting any frame in progress without o_done.
REQ-028 On reset, all outputs SHALL be 0 and the counters and latched angle SHALL be 0; o_pix SHALL be 0, not BG_PIXEL.

Configuration
REQ-029 With macro ROTATE_SCAN_TIMEOUT_EN defined: SHALL add parameter TIMEOUT_CYC (default 64); a cycle counter clears on WAIT_ROT entry, and after TIMEOUT_CYC cycles in WAIT_ROT with no i_rot_valid, SHALL pulse o_err for one cycle and go to IDLE without o_done.
REQ-030 Without ROTATE_SCAN_TIMEOUT_EN: WAIT_ROT SHALL wait indefinitely, o_err SHALL be tied to 0 and no counter logic SHALL exist.

Verification (IMAGE_SIZE=4, COOR_WIDTH=2)
REQ-031 Angle 0, rotator echoes coordinates, reads return H+4V, ready always high -> 16 pixels in raster order with o_pix=0..15, then one o_done pulse.
REQ-032 Rotator asserts i_rot_oor for destination (2,1), BG_PIXEL=16'hABCD -> that pixel outputs ABCD with no o_rd_req for it.
REQ-033 i_pix_ready held low for 5 cycles at pixel (0,0) -> o_pix_valid, o_pix and o_pix_H/V stay constant for those 5 cycles with no counter advance.
REQ-034 i_start pulsed mid-frame with angle 90 -> ignored; the whole frame uses the original angle and exactly 16 pixels are output.
REQ-035 i_rst asserted in READ of pixel 5 -> next cycle all outputs are 0 and the state is IDLE; a new i_start restarts at (0,0).
REQ-036 With ROTATE_SCAN_TIMEOUT_EN and TIMEOUT_CYC=8, rotator silent -> o_err pulses exactly once after 8 WAIT_ROT cycles, then o_busy=0 and no o_done.

Source files
------------

// File: rtl/rotate_scan_ctrl.sv
// rtl/rotate_scan_ctrl.sv - raster-scan controller driving a coordinate rotator, SRAM read and pixel stream; optional WAIT_ROT timeout under ROTATE_SCAN_TIMEOUT_EN
module rotate_scan_ctrl #(
    parameter int                   IMAGE_SIZE = 64,
    parameter int                   COOR_WIDTH = 6,
    parameter int                   ANG_WIDTH  = 9,
    parameter int                   PIX_WIDTH  = 16,
    parameter logic [PIX_WIDTH-1:0] BG_PIXEL   = '0
`ifdef ROTATE_SCAN_TIMEOUT_EN
    ,
    parameter int                   TIMEOUT_CYC = 64
`endif
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic signed [ANG_WIDTH-1:0] i_angle,
    output logic                        o_rot_start,
    output logic [COOR_WIDTH-1:0]       o_rot_H,
    output logic [COOR_WIDTH-1:0]       o_rot_V,
    output logic signed [ANG_WIDTH-1:0] o_rot_angle,
    input  logic                        i_rot_valid,
    input  logic [COOR_WIDTH-1:0]       i_rot_H,
    input  logic [COOR_WIDTH-1:0]       i_rot_V,
    input  logic                        i_rot_oor,
    output logic                        o_rd_req,
    output logic [COOR_WIDTH-1:0]       o_rd_H,
    output logic [COOR_WIDTH-1:0]       o_rd_V,
    input  logic                        i_rd_valid,
    input  logic [PIX_WIDTH-1:0]        i_rd_data,
    output logic                        o_pix_valid,
    input  logic                        i_pix_ready,
    output logic [PIX_WIDTH-1:0]        o_pix,
    output logic [COOR_WIDTH-1:0]       o_pix_H,
    output logic [COOR_WIDTH-1:0]       o_pix_V,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ROT      = 3'd1,
        WAIT_ROT = 3'd2,
        READ     = 3'd3,
        OUT      = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [COOR_WIDTH-1:0] COOR_MAX = COOR_WIDTH'(IMAGE_SIZE - 1);

    state_t                        state;
    state_t                        state_next;
    logic [COOR_WIDTH-1:0]         h_cnt;
    logic [COOR_WIDTH-1:0]         v_cnt;
    logic signed [ANG_WIDTH-1:0]   angle_q;
    logic                          last_pix;
    logic                          timeout_hit;

    // Destination counters double as rotator command and output coordinates
    assign o_rot_H     = h_cnt;
    assign o_rot_V     = v_cnt;
    assign o_pix_H     = h_cnt;
    assign o_pix_V     = v_cnt;
    assign o_rot_angle = angle_q;
    assign last_pix    = (h_cnt == COOR_MAX) && (v_cnt == COOR_MAX);

`ifdef ROTATE_SCAN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = (state == WAIT_ROT) && !i_rot_valid &&
                         (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Count cycles spent in WAIT_ROT; cleared on the way in, pulse o_err on expiry
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            to_cnt <= '0;
            o_err  <= 1'b0;
        end else begin
            o_err <= timeout_hit;
            if (state == WAIT_ROT) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_err       = 1'b0;
`endif

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (i_start) state_next = ROT;
            ROT:      state_next = WAIT_ROT;
            WAIT_ROT: begin
                if (i_rot_valid) begin
                    state_next = i_rot_oor ? OUT : READ;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            READ:     if (i_rd_valid) state_next = OUT;
            OUT:      if (i_pix_ready) state_next = last_pix ? DONE : ROT;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // State register, registered status strobes derived from next state, datapath
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            angle_q     <= '0;
            o_rd_H      <= '0;
            o_rd_V      <= '0;
            o_pix       <= '0;
            o_busy      <= 1'b0;
            o_rot_start <= 1'b0;
            o_rd_req    <= 1'b0;
            o_pix_valid <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state       <= state_next;
            o_busy      <= (state_next != IDLE);
            o_rot_start <= (state_next == ROT);
            o_rd_req    <= (state_next == READ);
            o_pix_valid <= (state_next == OUT);
            o_done      <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (i_start) begin
                        angle_q <= i_angle;
                        h_cnt   <= '0;
                        v_cnt   <= '0;
                    end
                end
                WAIT_ROT: begin
                    if (i_rot_valid) begin
                        if (i_rot_oor) begin
                            o_pix <= BG_PIXEL;
                        end else begin
                            o_rd_H <= i_rot_H;
                            o_rd_V <= i_rot_V;
                        end
                    end
                end
                READ: begin
                    if (i_rd_valid) o_pix <= i_rd_data;
                end
                OUT: begin
                    if (i_pix_ready) begin
                        h_cnt <= h_cnt + 1'b1;
                        if (h_cnt == COOR_MAX) v_cnt <= v_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_scan_ctrl.sv
// tb/tb_rotate_scan_ctrl.sv - scoreboard bench for rotate_scan_ctrl on a 4x4 image
module tb_rotate_scan_ctrl;

    localparam int CW = 2;
    localparam int AW = 9;
    localparam int PW = 16;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic                 i_start;
    logic signed [AW-1:0] i_angle;
    logic                 o_rot_start;
    logic [CW-1:0]        o_rot_H, o_rot_V;
    logic signed [AW-1:0] o_rot_angle;
    logic                 i_rot_valid;
    logic [CW-1:0]        i_rot_H, i_rot_V;
    logic                 i_rot_oor;
    logic                 o_rd_req;
    logic [CW-1:0]        o_rd_H, o_rd_V;
    logic                 i_rd_valid;
    logic [PW-1:0]        i_rd_data;
    logic                 o_pix_valid;
    logic                 i_pix_ready;
    logic [PW-1:0]        o_pix;
    logic [CW-1:0]        o_pix_H, o_pix_V;
    logic                 o_busy, o_done, o_err;

    always #5 i_clk = ~i_clk;

    rotate_scan_ctrl #(
        .IMAGE_SIZE(4), .COOR_WIDTH(CW), .ANG_WIDTH(AW), .PIX_WIDTH(PW),
        .BG_PIXEL(16'hABCD)
`ifdef ROTATE_SCAN_TIMEOUT_EN
        , .TIMEOUT_CYC(8)
`endif
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_angle(i_angle),
        .o_rot_start(o_rot_start), .o_rot_H(o_rot_H), .o_rot_V(o_rot_V),
        .o_rot_angle(o_rot_angle), .i_rot_valid(i_rot_valid), .i_rot_H(i_rot_H),
        .i_rot_V(i_rot_V), .i_rot_oor(i_rot_oor), .o_rd_req(o_rd_req),
        .o_rd_H(o_rd_H), .o_rd_V(o_rd_V), .i_rd_valid(i_rd_valid),
        .i_rd_data(i_rd_data), .o_pix_valid(o_pix_valid), .i_pix_ready(i_pix_ready),
        .o_pix(o_pix), .o_pix_H(o_pix_H), .o_pix_V(o_pix_V), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    typedef struct {
        logic [CW-1:0] h;
        logic [CW-1:0] v;
        logic [PW-1:0] d;
    } exp_t;

    exp_t                 exp_q[$];
    int                   errors = 0;
    int                   checks = 0;
    logic signed [AW-1:0] exp_angle = '0;
    bit                   rot_en = 1'b1;
    bit                   oor_en = 1'b0;
    bit                   stall_en = 1'b0;
    int                   stall_left = 0;
    int                   rd_cnt = 0;
    int                   done_seen = 0;
    int                   err_seen = 0;
    logic                 pend = 1'b0;
    logic [CW-1:0]        pend_h = '0, pend_v = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Rotator echo model (answers on first WAIT_ROT cycle), zero-latency SRAM, ready with optional stall
    always @(negedge i_clk) begin
        i_rot_valid = pend;
        i_rot_H     = pend_h;
        i_rot_V     = pend_v;
        i_rot_oor   = pend && oor_en && pend_h == 2'd2 && pend_v == 2'd1;
        pend        = rot_en && o_rot_start;
        pend_h      = o_rot_H;
        pend_v      = o_rot_V;
        i_rd_valid  = o_rd_req;
        i_rd_data   = 16'(o_rd_H) + 16'(o_rd_V) * 16'd4;
        if (o_rd_req) rd_cnt++;
        if (stall_en && o_pix_valid && o_pix_H == 2'd0 && o_pix_V == 2'd0 && stall_left > 0) begin
            i_pix_ready = 1'b0;
            stall_left--;
            chk("stall_hold", {11'd0, o_pix_valid, o_pix_H, o_pix_V, o_pix},
                {11'd0, 1'b1, 2'd0, 2'd0, 16'd0});
        end else begin
            i_pix_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each output handshake, checks angle and done
    always begin : monitor
        exp_t e;
        @(negedge i_clk);
        #1;
        if (!i_rst) begin
            if (o_rot_start) chk("rot_angle", 32'(o_rot_angle), 32'(exp_angle));
            if (o_pix_valid && i_pix_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pix_extra: got pixel %0h at (%0d,%0d) expected none", o_pix, o_pix_H, o_pix_V);
                end else begin
                    e = exp_q.pop_front();
                    chk("pix_data", 32'(o_pix), 32'(e.d));
                    chk("pix_coord", {28'd0, o_pix_H, o_pix_V}, {28'd0, e.h, e.v});
                end
            end
            if (o_done) begin
                done_seen++;
                chk("done_q_empty", exp_q.size(), 0);
            end
            if (o_err) err_seen++;
        end
    end

    task automatic push_frame(input bit oor);
        for (int v = 0; v < 4; v++) begin
            for (int h = 0; h < 4; h++) begin
                exp_q.push_back('{h: 2'(h), v: 2'(v),
                    d: (oor && h == 2 && v == 1) ? 16'hABCD : 16'(h + 4 * v)});
            end
        end
    endtask

    task automatic run_frame(input logic signed [AW-1:0] ang, input bit oor,
                             input bit stall, input bit midstart);
        int d0;
        int cyc;
        push_frame(oor);
        oor_en     = oor;
        stall_en   = stall;
        stall_left = stall ? 5 : 0;
        rd_cnt     = 0;
        exp_angle  = ang;
        d0         = done_seen;
        @(negedge i_clk);
        i_start = 1'b1;
        i_angle = ang;
        @(negedge i_clk);
        i_start = 1'b0;
        i_angle = '0;
        cyc = 0;
        while (done_seen == d0 && cyc < 2000) begin
            @(negedge i_clk);
            cyc++;
            if (midstart && cyc == 20) begin
                i_start = 1'b1;
                i_angle = 9'sd90;
            end else begin
                i_start = 1'b0;
            end
        end
        chk("frame_bound", (cyc < 2000), 1);
        @(negedge i_clk);
        chk("frame_done_count", done_seen - d0, 1);
        chk("frame_rd_count", rd_cnt, oor ? 15 : 16);
        chk("frame_q_empty", exp_q.size(), 0);
        chk("frame_idle", {31'd0, o_busy}, 0);
        if (stall) chk("stall_cycles_used", stall_left, 0);
        exp_q.delete();
        stall_en = 1'b0;
        oor_en   = 1'b0;
    endtask

    initial begin
        int d0;
        int cyc;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_angle = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_status", {26'd0, o_busy, o_done, o_err, o_rot_start, o_rd_req, o_pix_valid}, 0);
        chk("rst_pix", 32'(o_pix), 0);
        chk("rst_coords", {24'd0, o_rot_H, o_rot_V, o_rd_H, o_rd_V}, 0);
        chk("rst_angle", 32'(o_rot_angle), 0);
        i_rst = 1'b0;

        run_frame(9'sd0, 1'b0, 1'b0, 1'b0);
        run_frame(9'sd30, 1'b1, 1'b0, 1'b0);
        run_frame(-9'sd45, 1'b0, 1'b1, 1'b0);
        run_frame(9'sd45, 1'b0, 1'b0, 1'b1);

        // Abort with reset during READ of pixel 5, i.e. destination (1,1)
        push_frame(1'b0);
        exp_angle = 9'sd60;
        d0 = done_seen;
        @(negedge i_clk);
        i_start = 1'b1;
        i_angle = 9'sd60;
        @(negedge i_clk);
        i_start = 1'b0;
        cyc = 0;
        while (!(o_rd_req && o_pix_H == 2'd1 && o_pix_V == 2'd1) && cyc < 500) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("abort_reach_read5", (cyc < 500), 1);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("abort_status", {26'd0, o_busy, o_done, o_err, o_rot_start, o_rd_req, o_pix_valid}, 0);
        chk("abort_pix", 32'(o_pix), 0);
        chk("abort_coords", {24'd0, o_pix_H, o_pix_V, o_rd_H, o_rd_V}, 0);
        chk("abort_angle", 32'(o_rot_angle), 0);
        i_rst = 1'b0;
        chk("abort_popped", exp_q.size(), 11);
        exp_q.delete();
        repeat (3) @(negedge i_clk);
        chk("abort_no_done", done_seen - d0, 0);

        run_frame(-9'sd90, 1'b0, 1'b0, 1'b0);

`ifdef ROTATE_SCAN_TIMEOUT_EN
        rot_en    = 1'b0;
        exp_angle = 9'sd10;
        d0        = err_seen;
        @(negedge i_clk);
        i_start = 1'b1;
        i_angle = 9'sd10;
        cyc = 0;
        while (!o_err && cyc < 200) begin
            @(negedge i_clk);
            i_start = 1'b0;
            cyc++;
        end
        chk("timeout_latency", cyc, 10);
        @(negedge i_clk);
        chk("timeout_after", {30'd0, o_err, o_busy}, 0);
        repeat (3) @(negedge i_clk);
        chk("timeout_err_once", err_seen - d0, 1);
        rot_en = 1'b1;
`else
        chk("err_never", err_seen, 0);
`endif
        chk("total_done", done_seen, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
